// File: rtl/alaw_pkg.sv
// Shared G.711 A-law definitions: widths, sample types and the pure encode/decode
// functions used by the codec datapath.
package alaw_pkg;

    localparam int LIN_W  = 13;
    localparam int ALAW_W = 8;
    localparam logic [7:0] ALAW_XOR = 8'h55;

    typedef logic signed [LIN_W-1:0] lin_t;
    typedef logic [ALAW_W-1:0] alaw_t;

    // Priority encoder from 12-bit magnitude to segment number.
    function automatic logic [2:0] alaw_seg_of(input logic [11:0] mag);
        logic [2:0] seg;
        if (mag[11])      seg = 3'd7;
        else if (mag[10]) seg = 3'd6;
        else if (mag[9])  seg = 3'd5;
        else if (mag[8])  seg = 3'd4;
        else if (mag[7])  seg = 3'd3;
        else if (mag[6])  seg = 3'd2;
        else if (mag[5])  seg = 3'd1;
        else              seg = 3'd0;
        return seg;
    endfunction

    // Builds the transmitted byte once sign, segment and magnitude are known.
    function automatic alaw_t alaw_compose(input logic sign, input logic [2:0] seg,
                                           input logic [11:0] mag);
        logic [11:0] shifted;
        logic [3:0]  man;
        if (seg < 3'd2) begin
            man = mag[4:1];
        end else begin
            shifted = mag >> seg;
            man = shifted[3:0];
        end
        return {~sign, seg, man} ^ ALAW_XOR;
    endfunction

    function automatic alaw_t alaw_encode(input lin_t lin);
        logic [11:0] mag;
        mag = lin[12] ? ~lin[11:0] : lin[11:0];
        return alaw_compose(lin[12], alaw_seg_of(mag), mag);
    endfunction

    // Returns the interval midpoint; every code maps inside +/-4032, so no clamp.
    function automatic lin_t alaw_decode(input alaw_t code);
        alaw_t       b;
        logic [2:0]  seg;
        logic [11:0] base;
        logic [11:0] t;
        b    = code ^ ALAW_XOR;
        seg  = b[6:4];
        base = {7'd0, b[3:0], 1'b1};
        if (seg == 3'd0) begin
            t = base;
        end else begin
            t = (base + 12'd32) << (seg - 3'd1);
        end
        if (b[7]) begin
            return lin_t'({1'b0, t});
        end else begin
            return lin_t'(13'd0 - {1'b0, t});
        end
    endfunction

endpackage

// File: rtl/alaw_seg_detect.sv
// Combinational segment detector: position of the highest set bit among mag[11:5].
module alaw_seg_detect
    import alaw_pkg::*;
(
    input  logic [11:0] mag,
    output logic [2:0]  seg
);

    // Priority search delegated to the shared package helper.
    always_comb begin
        seg = 3'd0;
        seg = alaw_seg_of(mag);
    end

endmodule

// File: rtl/alaw_codec.sv
// Registered G.711 A-law codec: independent 1-cycle encode and decode pipelines.
module alaw_codec
    import alaw_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] lin_in,
    input  logic        lin_valid,
    output logic [7:0]  alaw_out,
    output logic        alaw_out_valid,
    input  logic [7:0]  alaw_in,
    input  logic        alaw_valid,
    output logic [12:0] lin_out,
    output logic        lin_out_valid
);

    logic [11:0] enc_mag;
    logic [2:0]  enc_seg;
    alaw_t       enc_code;
    lin_t        dec_lin;

    // Negative samples use one's complement so -1 and -4096 land on the magnitude extremes.
    always_comb begin
        enc_mag = 12'd0;
        if (lin_in[12]) begin
            enc_mag = ~lin_in[11:0];
        end else begin
            enc_mag = lin_in[11:0];
        end
    end

    alaw_seg_detect u_seg_detect (
        .mag (enc_mag),
        .seg (enc_seg)
    );

    // Combinational encode and decode results feeding the output registers.
    always_comb begin
        enc_code = alaw_compose(lin_in[12], enc_seg, enc_mag);
        dec_lin  = alaw_decode(alaw_in);
    end

    // Encoder output stage: load on valid, otherwise hold data and drop valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alaw_out       <= 8'h00;
            alaw_out_valid <= 1'b0;
        end else if (lin_valid) begin
            alaw_out       <= enc_code;
            alaw_out_valid <= 1'b1;
        end else begin
            alaw_out_valid <= 1'b0;
        end
    end

    // Decoder output stage: same hold behaviour as the encoder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lin_out       <= 13'h0000;
            lin_out_valid <= 1'b0;
        end else if (alaw_valid) begin
            lin_out       <= 13'(dec_lin);
            lin_out_valid <= 1'b1;
        end else begin
            lin_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alaw_codec.sv
// Self-checking bench for alaw_codec: directed corner table, reset, hold/gap,
// exhaustive encode->decode loopback sweep and exhaustive decode->encode check.
module tb_alaw_codec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] lin_in;
    logic        lin_valid;
    logic [7:0]  alaw_out;
    logic        alaw_out_valid;
    logic [7:0]  alaw_in_drv;
    logic        alaw_valid_drv;
    logic [7:0]  alaw_in_dut;
    logic        alaw_valid_dut;
    logic [12:0] lin_out;
    logic        lin_out_valid;
    logic        loop_mode;

    int vec_count = 0;
    int err_count = 0;

    assign alaw_in_dut    = loop_mode ? alaw_out : alaw_in_drv;
    assign alaw_valid_dut = loop_mode ? alaw_out_valid : alaw_valid_drv;

    alaw_codec dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lin_in         (lin_in),
        .lin_valid      (lin_valid),
        .alaw_out       (alaw_out),
        .alaw_out_valid (alaw_out_valid),
        .alaw_in        (alaw_in_dut),
        .alaw_valid     (alaw_valid_dut),
        .lin_out        (lin_out),
        .lin_out_valid  (lin_out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         lin;
        logic [7:0] alaw_exp;
        logic [7:0] code;
        logic [12:0] lin_exp;
    } vec_t;

    // Reference encoder: segment found by threshold search.
    function automatic logic [7:0] m_enc(input int x);
        int mag, seg, man;
        logic [7:0] c;
        mag = (x < 0) ? (-x - 1) : x;
        seg = 0;
        while (seg < 7 && mag >= (32 << seg)) seg++;
        man = (seg < 2) ? ((mag >> 1) & 15) : ((mag >> seg) & 15);
        c = 8'(((x < 0) ? 0 : 128) | (seg << 4) | man);
        return c ^ 8'h55;
    endfunction

    function automatic int m_dec(input logic [7:0] code);
        logic [7:0] b;
        int seg, man, t;
        b   = code ^ 8'h55;
        seg = int'(b[6:4]);
        man = int'(b[3:0]);
        t   = (seg == 0) ? (2 * man + 1) : ((2 * man + 33) * (1 << (seg - 1)));
        return b[7] ? t : -t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[5];

    initial begin
        int d;
        vecs[0] = '{lin: 0,     alaw_exp: 8'hD5, code: 8'hD5, lin_exp: 13'h0001};
        vecs[1] = '{lin: 4095,  alaw_exp: 8'hAA, code: 8'hAA, lin_exp: 13'h0FC0};
        vecs[2] = '{lin: -1,    alaw_exp: 8'h55, code: 8'h55, lin_exp: 13'h1FFF};
        vecs[3] = '{lin: -4096, alaw_exp: 8'h2A, code: 8'h2A, lin_exp: 13'h1040};
        vecs[4] = '{lin: 32,    alaw_exp: 8'hC5, code: 8'hC5, lin_exp: 13'h0021};

        rst_n = 1'b0; loop_mode = 1'b0;
        lin_in = 13'd0; lin_valid = 1'b0;
        alaw_in_drv = 8'd0; alaw_valid_drv = 1'b0;
        tick(); tick();
        check("rst_alaw_out", int'(alaw_out), 0);
        check("rst_lin_out", int'(lin_out), 0);
        check("rst_valids", int'({alaw_out_valid, lin_out_valid}), 0);
        rst_n = 1'b1;
        tick();

        // Corner table: encode and decode run in the same cycle.
        for (int i = 0; i < 5; i++) begin
            lin_in = 13'(vecs[i].lin); lin_valid = 1'b1;
            alaw_in_drv = vecs[i].code; alaw_valid_drv = 1'b1;
            tick();
            check("enc_corner", int'(alaw_out), int'(vecs[i].alaw_exp));
            check("enc_valid", int'(alaw_out_valid), 1);
            check("dec_corner", int'(lin_out), int'(vecs[i].lin_exp));
            check("dec_valid", int'(lin_out_valid), 1);
        end

        // Hold/gap: inputs change but valids are low for 3 cycles.
        lin_in = 13'd0; alaw_in_drv = 8'hAA;
        tick();
        lin_valid = 1'b0; alaw_valid_drv = 1'b0;
        for (int g = 0; g < 3; g++) begin
            lin_in = 13'(1234 + g); alaw_in_drv = 8'(8'h13 + g);
            tick();
            check("gap_alaw_hold", int'(alaw_out), 'hD5);
            check("gap_lin_hold", int'(lin_out), 'h0FC0);
            check("gap_valids", int'({alaw_out_valid, lin_out_valid}), 0);
        end

        // Mid-stream asynchronous reset discards the sample in flight.
        lin_in = 13'd100; lin_valid = 1'b1; alaw_in_drv = 8'h2A; alaw_valid_drv = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_alaw", int'(alaw_out), 0);
        check("async_rst_lin", int'(lin_out), 0);
        check("async_rst_valids", int'({alaw_out_valid, lin_out_valid}), 0);
        lin_valid = 1'b0; alaw_valid_drv = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_valids", int'({alaw_out_valid, lin_out_valid}), 0);
        check("post_rst_alaw", int'(alaw_out), 0);

        // Exhaustive loopback sweep with valid held high every cycle.
        loop_mode = 1'b1;
        for (int i = 0; i <= 8192; i++) begin
            int x, xp, err, half, mag, seg;
            x = i - ((i >= 4096) ? 8192 : 0);
            if (i < 8192) begin
                lin_in = 13'(i); lin_valid = 1'b1;
            end else begin
                lin_valid = 1'b0;
            end
            tick();
            if (i < 8192) begin
                check("loop_enc", int'(alaw_out), int'(m_enc(x)));
                check("loop_enc_valid", int'(alaw_out_valid), 1);
            end
            if (i >= 1) begin
                xp   = (i - 1) - (((i - 1) >= 4096) ? 8192 : 0);
                mag  = (xp < 0) ? (-xp - 1) : xp;
                seg  = 0;
                while (seg < 7 && mag >= (32 << seg)) seg++;
                half = (seg < 2) ? 1 : ((1 << seg) / 2);
                d    = int'($signed(lin_out));
                err  = (d > xp) ? (d - xp) : (xp - d);
                check("loop_dec_valid", int'(lin_out_valid), 1);
                vec_count++;
                if (err > half) begin
                    err_count++;
                    $display("FAIL loop_err: x=%0d decoded %0d error %0d exceeds bound %0d", xp, d, err, half);
                end
            end
        end
        loop_mode = 1'b0;
        lin_valid = 1'b0;
        tick();

        // Every code decodes correctly and re-encodes to itself.
        for (int c = 0; c < 256; c++) begin
            alaw_in_drv = 8'(c); alaw_valid_drv = 1'b1; lin_valid = 1'b0;
            tick();
            d = int'($signed(lin_out));
            check("exh_dec", d, m_dec(8'(c)));
            alaw_valid_drv = 1'b0;
            lin_in = lin_out; lin_valid = 1'b1;
            tick();
            check("exh_reenc", int'(alaw_out), c);
        end
        lin_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
